// File: rtl/instr_fetch_if.sv
// Instruction-fetch bundle: imem request/response port plus the decoded-instruction hand-off.
// The master modport belongs to the fetch unit; the slave modport belongs to memory and the datapath.
interface instr_fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic [6:0]      opcode;
    logic            inst_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     fetch_cnt;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc, opcode, fetch_cnt,
        input  inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc, opcode, fetch_cnt,
        output inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word at a time over imem and presents it until retired.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misaligned flag and a HALT state for misaligned redirects.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            fetch_misaligned,
`endif
    instr_fetch_if.master   bus
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            req_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            inst_valid_q;
    logic [31:0]     fetch_cnt_q;
    logic            rsp_fire;
    logic            retire;
    logic            misalign_hit;
    logic [XLEN-1:0] target;

    // Redirect target: misaligned targets either halt fetch or get their low bits dropped
`ifdef FETCH_MISALIGN_CHECK_EN
    assign target = bus.redirect_pc;
`else
    assign target = bus.redirect_pc & ~XLEN'(3);
`endif

    assign pc_next = bus.redirect_valid ? target : pc_q + XLEN'(4);

    // Next-state and event decode
    always_comb begin
        state_next   = state;
        rsp_fire     = 1'b0;
        retire       = 1'b0;
        misalign_hit = 1'b0;
        case (state)
            ST_REQ: begin
                if (req_valid_q && bus.imem_req_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    rsp_fire   = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.inst_ready) begin
                    retire     = 1'b1;
                    state_next = ST_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
                        misalign_hit = 1'b1;
                        state_next   = ST_HALT;
                    end
`endif
                end
            end
            default: state_next = state;
        endcase
    end

    // State register; req_valid tracks the state being entered so it is low only in the first cycle after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_REQ;
            req_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            req_valid_q <= (state_next == ST_REQ);
        end
    end

    // PC, instruction latch and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            if (rsp_fire) begin
                inst_q       <= bus.imem_rsp_data;
                inst_pc_q    <= pc_q;
                inst_valid_q <= 1'b1;
            end
            if (retire) begin
                inst_q       <= NOP_INST;
                inst_valid_q <= 1'b0;
                fetch_cnt_q  <= fetch_cnt_q + 32'd1;
                pc_q         <= pc_next;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               fetch_misaligned <= 1'b0;
        else if (misalign_hit) fetch_misaligned <= 1'b1;
    end
`endif

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.opcode         = inst_q[6:0];
    assign bus.fetch_cnt      = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model (request outstanding / instruction held) checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;
    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.XLEN(XLEN)) bus();
`ifdef FETCH_MISALIGN_CHECK_EN
    logic fetch_misaligned;
`endif

    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk(clk),
        .rst(rst),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misaligned(fetch_misaligned),
`endif
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a fetch is either not yet started (fresh), outstanding at memory, or held for the datapath
    logic [31:0] m_pc, m_inst, m_inst_pc, m_cnt;
    logic        m_fresh, m_out, m_hold, m_halt;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        m_mis;
`endif
    int          cyc;
    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    int          first_valid_cyc;

    function automatic logic exp_rv();
        return !m_fresh && !m_out && !m_hold && !m_halt;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv()));
        if (exp_rv()) chk("req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
        chk("inst_valid", 64'(bus.inst_valid), 64'(m_hold));
        chk("inst", 64'(bus.inst), 64'(m_hold ? m_inst : NOP));
        chk("opcode", 64'(bus.opcode), 64'(m_hold ? m_inst[6:0] : 7'b0010011));
        if (m_hold) chk("inst_pc", 64'(bus.inst_pc), 64'(m_inst_pc));
        chk("fetch_cnt", 64'(bus.fetch_cnt), 64'(m_cnt));
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("fetch_misaligned", 64'(fetch_misaligned), 64'(m_mis));
`endif
    endtask

    // One clock: drive inputs, advance the model by the rules, then check outputs at the falling edge
    task automatic step(input logic rdy, input logic rspv, input logic [31:0] rspd,
                        input logic ir, input logic redir, input logic [31:0] rpc);
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rspd;
        bus.inst_ready     = ir;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (m_hold) begin
            if (ir) begin
                m_hold = 1'b0;
                m_cnt  = m_cnt + 32'd1;
                if (!redir) m_pc = m_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
                else begin
                    m_pc = rpc;
                    if (rpc % 4 != 0) begin
                        m_mis  = 1'b1;
                        m_halt = 1'b1;
                    end
                end
`else
                else m_pc = rpc - (rpc % 4);
`endif
            end
        end else if (m_out) begin
            if (rspv) begin
                m_out     = 1'b0;
                m_hold    = 1'b1;
                m_inst    = rspd;
                m_inst_pc = m_pc;
            end
        end else if (!m_halt && rdy) begin
            m_out = 1'b1;
            acc_q.push_back(m_pc);
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (m_hold && first_valid_cyc < 0) first_valid_cyc = cyc;
        check_all();
    endtask

    // Reset mid-flight with a response offered throughout; it must be dropped
    task automatic do_reset();
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        #1;
        m_pc = RESET_PC; m_inst = NOP; m_inst_pc = RESET_PC; m_cnt = '0;
        m_fresh = 1'b1; m_out = 1'b0; m_hold = 1'b0; m_halt = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        m_mis = 1'b0;
`endif
        check_all();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        acc_q.delete();
        acc_cyc.delete();
        cyc = 0;
        first_valid_cyc = -1;
    endtask

    initial begin
        logic [31:0] saved_addr, saved_inst, saved_pc, saved_cnt, rpc;
        logic        found;

        // Test 1: zero-wait memory, back-to-back retire
        do_reset();
        chk("reset_inst_literal", 64'(bus.inst), 64'h13);
        chk("reset_req_valid_literal", 64'(bus.imem_req_valid), 64'h0);
        repeat (10) step(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
        chk("t1_accepts", 64'(acc_q.size() >= 3), 64'h1);
        if (acc_q.size() >= 3) begin
            chk("t1_addr0", 64'(acc_q[0]), 64'h0);
            chk("t1_addr1", 64'(acc_q[1]), 64'h4);
            chk("t1_addr2", 64'(acc_q[2]), 64'h8);
            chk("t1_latency", 64'(first_valid_cyc - acc_cyc[0]), 64'd2);
        end

        // Test 2: back-pressure on the request
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (exp_rv()) found = 1'b1;
            else step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
        end
        chk("t2_reach_req", 64'(found), 64'h1);
        saved_addr = bus.imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 32'h100);
            chk("t2_valid_held", 64'(bus.imem_req_valid), 64'h1);
            chk("t2_addr_stable", 64'(bus.imem_req_addr), 64'(saved_addr));
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Test 3: datapath stall while an instruction is held
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_hold) found = 1'b1;
            else step(1'b1, 1'b1, 32'h0000_00B3 | ($urandom & 32'hFFFF_FF00), 1'b0, 1'b0, 32'h0);
        end
        chk("t3_reach_hold", 64'(found), 64'h1);
        saved_inst = bus.inst; saved_pc = bus.inst_pc; saved_cnt = bus.fetch_cnt;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, $urandom, 1'b0, 1'b1, 32'h200);
            chk("t3_inst_stable", 64'(bus.inst), 64'(saved_inst));
            chk("t3_pc_stable", 64'(bus.inst_pc), 64'(saved_pc));
            chk("t3_cnt_stable", 64'(bus.fetch_cnt), 64'(saved_cnt));
        end
        chk("t3_opcode_literal", 64'(bus.opcode), 64'h33);

        // Test 4: redirect from the instruction at 0x10
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_hold && m_inst_pc == 32'h10) found = 1'b1;
            else step(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
        end
        chk("t4_reach_0x10", 64'(found), 64'h1);
        chk("t4_cnt_literal", 64'(bus.fetch_cnt), 64'd4);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        chk("t4_req_valid", 64'(bus.imem_req_valid), 64'h1);
        chk("t4_req_addr", 64'(bus.imem_req_addr), 64'h40);

        // Test 5: reset while a response is pending
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t5_outstanding", 64'(m_out), 64'h1);
        do_reset();
        step(1'b0, 1'b1, 32'h1234_5677, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h1234_5677, 1'b1, 1'b0, 32'h0);
        chk("t5_inst_valid", 64'(bus.inst_valid), 64'h0);
        chk("t5_req_valid", 64'(bus.imem_req_valid), 64'h1);
        chk("t5_req_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            step(($urandom % 3) != 0, $urandom % 2 == 0, $urandom, $urandom % 2 == 0,
                 $urandom % 4 == 0, rpc);
        end
        chk("rand_progress", 64'(m_cnt > 100), 64'h1);

        // Test 6: misaligned redirect to 0x42
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_hold) found = 1'b1;
            else step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        end
        chk("t6_reach_hold", 64'(found), 64'h1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            chk("t6_misaligned", 64'(fetch_misaligned), 64'h1);
            chk("t6_no_req", 64'(bus.imem_req_valid), 64'h0);
            chk("t6_no_inst", 64'(bus.inst_valid), 64'h0);
            step(1'b1, 1'b1, $urandom, 1'b1, 1'b1, 32'h80);
        end
`else
        chk("t6_req_valid", 64'(bus.imem_req_valid), 64'h1);
        chk("t6_req_addr", 64'(bus.imem_req_addr), 64'h40);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
